mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the shared 16-bit memory bus (DRAM plus MMIO, read/write strobes, `addr`, `d_in`, OR-combined `d_out`). Sits between the core's requesters (e.g. CPU data port and a port/DMA engine) and the memory block. Serialises accesses with round-robin fairness, drives one-cycle memory strobes, and returns read data to the owning requester after a fixed memory read latency.

## Interface
- `RD_LATENCY`, 1: cycles from the cycle after the strobe to valid `mem_d_out`; legal 1..3.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  [1:0]  per-requester access request; held until the matching `gnt`.
- `we`  in  [1:0]  per-requester 1 = write, 0 = read; held with `req`.
- `addr`  in  [15:0] x2 (`[0:1]`)  per-requester address.
- `wdata`  in  [15:0] x2 (`[0:1]`)  per-requester write data.
- `gnt`  out  [1:0]  one-cycle pulse: request accepted, strobe on bus this cycle.
- `rvalid`  out  [1:0]  one-cycle pulse: `rdata` valid for that requester.
- `rdata`  out  16  captured read data, shared by both requesters.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `mem_addr`, `mem_d_in`  out  16 each  memory address and write data.
- `mem_d_out`  in  16  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` is high, pick a winner, register its `addr`/`wdata`/`we` into the `mem_*` outputs, then go to ISSUE. With no request, stay in IDLE.
- Winner selection: if one request is high, it wins. If both are high, the requester not granted last wins. Pointer `last` resets to 1, so requester 0 wins the first tie.
- ISSUE (one cycle): `gnt[w]=1`. Exactly one of `mem_write` or `mem_read` is high. A write goes to IDLE; a read goes to WAIT with the counter at RD_LATENCY.
- WAIT: decrement the counter each cycle. In the last WAIT cycle, capture `mem_d_out` into `rdata`, then go to RESP.
- RESP (one cycle): `rvalid[w]=1`, `rdata` valid. Then go to IDLE.
- `req` is sampled only in IDLE. A `req` still high during ISSUE/WAIT/RESP is ignored until the next IDLE.
- A requester drops `req` on the edge after it sees `gnt`. If `req` is still high at the next IDLE, it is a new request.
- `mem_addr`/`mem_d_in` are 0 outside ISSUE, so the OR-combined memory output stays clean.
- `rdata` holds its last captured value until the next capture.
- Reset (async, any state, including mid-read): state=IDLE, `last`=1, counter=0. All outputs drive 0 immediately. An in-flight read is discarded and never produces `rvalid`.

## Timing
- Request high in IDLE cycle C leads to `gnt` plus strobe in C+1.
- Write: complete at C+1. The next IDLE is C+2, so the maximum write rate is one per 2 cycles.
- Read: WAIT occupies C+2 .. C+1+RD_LATENCY. `rvalid`/`rdata` appear in C+2+RD_LATENCY. Next IDLE is C+3+RD_LATENCY.
- All outputs are registered; there is no combinational path from `req` to `gnt` or to `mem_*`.
- Reset value of every output is 0.

## Structure
- Package `mem_arb_pkg` holds the state enum (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`), `ARB_REQ_COUNT = 2`, and the 2-bit latency counter width.
- One sub-module: `rr_pick2`, a combinational round-robin pick from `req[1:0]` and `last`. It outputs a winner index and an `any` flag.
- `mem_arbiter` holds the FSM, the pointer, the counter, and the output registers.

## Test plan
- Write, requester 0, addr 0x0010, wdata 0xBEEF, req in cycle C -> in C+1: `gnt=01`, `mem_write=1`, `mem_addr=0x0010`, `mem_d_in=0xBEEF`. All strobes are 0 in C+2.
- Read, requester 1, addr 0x0010 after that write, RD_LATENCY=1 -> `mem_read=1` in C+1; `rvalid=10` with `rdata=0xBEEF` in C+3; `rvalid[0]` stays 0.
- Both requesters write continuously from reset -> grants alternate 01, 10, 01, 10, one grant every 2 cycles, requester 0 first.
- Requester 0 alone holds `req` high for 10 cycles (writes) -> `gnt[0]` pulses in every other cycle (5 grants); `gnt[1]` is never high.
- RD_LATENCY=3, read of 0x1234 returning 0xA5A5 -> `rvalid` in C+5 with `rdata=0xA5A5`; no strobe during C+2..C+4.
- `rst` asserted mid-WAIT of a read -> all outputs 0 in the same cycle. After release: no `rvalid`, state IDLE, and the next tie is granted to requester 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   ARB_REQ_COUNT : number of requesters served by mem_arbiter
//   ARB_CNT_W     : width of the read-latency down-counter
//   arb_state_t   : sequencer state encoding
package mem_arb_pkg;

  localparam int ARB_REQ_COUNT = 2;
  localparam int ARB_CNT_W     = 2;

  typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin pick between two requesters.
//   req  : request vector
//   last : index of the requester granted most recently
//   win  : index of the chosen requester (valid when any = 1)
//   any  : at least one request is pending
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);

  assign any = |req;
  // On a tie the requester that was not served last goes first; otherwise
  // the single active requester wins (req[1] is its index).
  assign win = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the shared 16-bit memory bus.
// Serialises two requesters with round-robin fairness, drives one-cycle
// memory strobes and returns read data after RD_LATENCY cycles.
//   clk, rst          : clock, asynchronous active-high reset
//   req, we           : per-requester request and write flag
//   addr, wdata       : per-requester address and write data
//   gnt               : one-cycle accept pulse, strobe on the bus that cycle
//   rvalid, rdata     : one-cycle read-return pulse and shared read data
//   mem_read/mem_write: memory strobes
//   mem_addr/mem_d_in : memory address and write data (zero when idle)
//   mem_d_out         : memory read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  // Cycles from the cycle after the read strobe to valid mem_d_out (1..3).
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [15:0] addr  [0:ARB_REQ_COUNT-1],
  input  logic [15:0] wdata [0:ARB_REQ_COUNT-1],
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [15:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_d_in,
  input  logic [15:0] mem_d_out
);

  localparam arb_cnt_t LAT_CNT = arb_cnt_t'(RD_LATENCY);

  arb_state_t  state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  arb_cnt_t    cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_d_in_q, mem_d_in_d;

  logic win;
  logic any;

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_d_in_d  = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          // Load the winner's access into the bus registers so the strobe,
          // address and data all appear together in the ISSUE cycle.
          owner_d     = win;
          last_d      = win;
          gnt_d       = win ? 2'b10 : 2'b01;
          mem_write_d = we[win];
          mem_read_d  = ~we[win];
          mem_addr_d  = addr[win];
          mem_d_in_d  = wdata[win];
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_write_q) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d   = LAT_CNT;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // Count reaching one marks the cycle in which mem_d_out is valid.
        if (cnt_q <= arb_cnt_t'(1)) begin
          rdata_d  = mem_d_out;
          rvalid_d = owner_q ? 2'b10 : 2'b01;
          cnt_d    = '0;
          state_d  = ARB_RESP;
        end else begin
          cnt_d = cnt_q - arb_cnt_t'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_d_in_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_d_in_q  <= mem_d_in_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_d_in  = mem_d_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Two instances: dut_a with
// RD_LATENCY=1 and dut_b with RD_LATENCY=3. A scoreboard per instance holds
// the expected bus activity, keyed by cycle number; every other cycle the
// bus is expected to be quiet with rdata holding its last returned value.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [1:0]  rv;
    logic [15:0] rdata;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  logic [15:0] model_rd_a;
  logic [15:0] model_rd_b;

  // Instance A signals (RD_LATENCY = 1)
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
  logic [15:0] addr_a [0:1];
  logic [15:0] wdata_a [0:1];
  logic [15:0] rdata_a, mem_addr_a, mem_d_in_a, mem_d_out_a;
  logic        mem_read_a, mem_write_a;

  // Instance B signals (RD_LATENCY = 3)
  logic [1:0]  req_b, we_b, gnt_b, rvalid_b;
  logic [15:0] addr_b [0:1];
  logic [15:0] wdata_b [0:1];
  logic [15:0] rdata_b, mem_addr_b, mem_d_in_b, mem_d_out_b;
  logic        mem_read_b, mem_write_b;

  mem_arbiter #(.RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
    .mem_d_in(mem_d_in_a), .mem_d_out(mem_d_out_a)
  );

  mem_arbiter #(.RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_d_in(mem_d_in_b), .mem_d_out(mem_d_out_b)
  );

  // Memory for A: writable, one-cycle read pipeline.
  logic [15:0] mem_a [0:255];
  logic [15:0] pipe_a;
  always @(posedge clk) begin
    if (mem_write_a) mem_a[mem_addr_a[7:0]] <= mem_d_in_a;
    pipe_a <= mem_read_a ? mem_a[mem_addr_a[7:0]] : 16'h0;
  end
  assign mem_d_out_a = pipe_a;

  // Memory for B: fixed content (0x1234 holds 0xA5A5), three-cycle pipeline.
  logic [15:0] pipe_b [0:2];
  always @(posedge clk) begin
    pipe_b[0] <= (mem_read_b && mem_addr_b == 16'h1234) ? 16'hA5A5 : 16'h0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_d_out_b = pipe_b[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [1:0] g, input logic rd, input logic wr,
                                       input logic [15:0] a, input logic [15:0] d,
                                       input logic [1:0] rv, input logic [15:0] rdat);
    return {10'd0, g, rd, wr, a, d, rv, rdat};
  endfunction

  function automatic logic [1:0] onehot(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic push(input int idx, input int c, input logic [1:0] g, input logic rd,
                      input logic wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] rv, input logic [15:0] rdat);
    ev_t e;
    e.cyc = c; e.gnt = g; e.rd = rd; e.wr = wr;
    e.addr = a; e.din = d; e.rv = rv; e.rdata = rdat;
    if (idx == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  task automatic score(input int idx, input logic [63:0] obs);
    ev_t         e;
    logic [15:0] mr;
    bit          hit;
    hit = 0;
    mr  = (idx == 0) ? model_rd_a : model_rd_b;
    if (idx == 0) begin
      if (q_a.size() > 0 && q_a[0].cyc == cyc) begin e = q_a.pop_front(); hit = 1; end
    end else begin
      if (q_b.size() > 0 && q_b[0].cyc == cyc) begin e = q_b.pop_front(); hit = 1; end
    end
    if (hit) begin
      check($sformatf("bus%0d_event_c%0d", idx, cyc), obs,
            pack(e.gnt, e.rd, e.wr, e.addr, e.din, e.rv, (e.rv != 2'b00) ? e.rdata : mr));
      if (e.rv != 2'b00) begin
        if (idx == 0) model_rd_a = e.rdata;
        else          model_rd_b = e.rdata;
      end
    end else begin
      check($sformatf("bus%0d_quiet_c%0d", idx, cyc), obs, pack(2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, mr));
    end
  endtask

  always @(negedge clk) begin
    score(0, pack(gnt_a, mem_read_a, mem_write_a, mem_addr_a, mem_d_in_a, rvalid_a, rdata_a));
    score(1, pack(gnt_b, mem_read_b, mem_write_b, mem_addr_b, mem_d_in_b, rvalid_b, rdata_b));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input int r, input logic v, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (idx == 0) begin
      req_a[r] = v; we_a[r] = w; addr_a[r] = a; wdata_a[r] = d;
    end else begin
      req_b[r] = v; we_b[r] = w; addr_b[r] = a; wdata_b[r] = d;
    end
  endtask

  // Single access on an idle arbiter; returns with the arbiter idle again.
  task automatic xfer(input int idx, input int r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input int lat, input logic [15:0] exp_rd);
    int c;
    c = cyc;
    drive(idx, r, 1'b1, w, a, d);
    push(idx, c + 1, onehot(r), ~w, w, a, d, 2'b00, 16'h0);
    if (!w) push(idx, c + 2 + lat, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, onehot(r), exp_rd);
    repeat (2) step();
    drive(idx, r, 1'b0, w, a, d);
    if (!w) repeat (lat + 1) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    model_rd_a = 16'h0;
    model_rd_b = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    n_checks = 0;
    n_errors = 0;
    model_rd_a = 16'h0;
    model_rd_b = 16'h0;
    req_a = '0; we_a = '0; req_b = '0; we_b = '0;
    for (int i = 0; i < 2; i++) begin
      addr_a[i] = '0; wdata_a[i] = '0; addr_b[i] = '0; wdata_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Write then read-back on A (RD_LATENCY=1).
    xfer(0, 0, 1'b1, 16'h0010, 16'hBEEF, 1, 16'h0);
    xfer(0, 1, 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF);
    step();

    // Read with RD_LATENCY=3 on B.
    xfer(1, 1, 1'b0, 16'h1234, 16'h0000, 3, 16'hA5A5);
    step();

    // Requester 0 read on B, reset asserted during WAIT (cycle c+3).
    c = cyc;
    drive(1, 0, 1'b1, 1'b0, 16'h1234, 16'h0000);
    push(1, c + 1, 2'b01, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'h0);
    repeat (2) step();
    drive(1, 0, 1'b0, 1'b0, 16'h1234, 16'h0000);
    step();
    rst = 1'b1;
    #1;
    check("rst_async_outputs_b",
          pack(gnt_b, mem_read_b, mem_write_b, mem_addr_b, mem_d_in_b, rvalid_b, rdata_b), 64'h0);
    do_reset();
    repeat (6) step();

    // Tie after reset on B: requester 0 first, then requester 1.
    c = cyc;
    drive(1, 0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    drive(1, 1, 1'b1, 1'b1, 16'h0030, 16'h6666);
    push(1, c + 1, 2'b01, 1'b0, 1'b1, 16'h0020, 16'h5555, 2'b00, 16'h0);
    push(1, c + 3, 2'b10, 1'b0, 1'b1, 16'h0030, 16'h6666, 2'b00, 16'h0);
    repeat (2) step();
    drive(1, 0, 1'b0, 1'b1, 16'h0020, 16'h5555);
    repeat (2) step();
    drive(1, 1, 1'b0, 1'b1, 16'h0030, 16'h6666);
    step();

    // Both requesters write continuously on A from reset.
    do_reset();
    c = cyc;
    drive(0, 0, 1'b1, 1'b1, 16'h0100, 16'h1111);
    drive(0, 1, 1'b1, 1'b1, 16'h0200, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(0, c + 1 + 2 * k, 2'b01, 1'b0, 1'b1, 16'h0100, 16'h1111, 2'b00, 16'h0);
      else            push(0, c + 1 + 2 * k, 2'b10, 1'b0, 1'b1, 16'h0200, 16'h2222, 2'b00, 16'h0);
    end
    repeat (8) step();
    drive(0, 0, 1'b0, 1'b1, 16'h0100, 16'h1111);
    drive(0, 1, 1'b0, 1'b1, 16'h0200, 16'h2222);
    step();

    // Requester 0 alone holds req for 10 cycles: five grants, none to 1.
    c = cyc;
    drive(0, 0, 1'b1, 1'b1, 16'h0044, 16'h4444);
    for (int k = 0; k < 5; k++)
      push(0, c + 1 + 2 * k, 2'b01, 1'b0, 1'b1, 16'h0044, 16'h4444, 2'b00, 16'h0);
    repeat (10) step();
    drive(0, 0, 1'b0, 1'b1, 16'h0044, 16'h4444);
    repeat (4) step();

    check("scoreboard_a_drained", 64'(q_a.size()), 64'h0);
    check("scoreboard_b_drained", 64'(q_b.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
